// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display driver.
// Segment vectors are active-low, bit 0 = segment a, bit 6 = segment g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  // Only segment g lit.
  localparam seg_t SEG_DASH  = 7'h3F;

  // Indexed by the 4-bit code: 0-9 digits, A dash, B-F blank.
  localparam seg_t SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

endpackage

// File: rtl/seg7_display_driver_bcd_to_seg.sv
// Combinational 4-bit code to active-low segment decoder.
// Ports:
//   code_i  4-bit BCD/extended code
//   seg_o   active-low segments a..g (bit 0 = a)
module bcd_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_PATTERNS[code_i];

endmodule

// File: rtl/seg7_display_driver.sv
// Time-multiplexed common-anode 7-segment display driver.
// Scans N_DIGITS digits, one per slot of SCAN_DIV cycles, with BLANK_CYCLES of
// all-anodes-off at the start of each slot to prevent ghosting. Inputs are
// snapshotted at each slot boundary so mid-slot changes never tear a digit.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   digits_i       BCD codes, digit k at [4k+3:4k], digit 0 rightmost
//   dp_i           per-digit decimal point request (active-high)
//   blink_mask_i   per-digit blink enable
//   enable_i       display on/off (counters keep running when off)
//   an_o           anode selects, active-low
//   seg_o          segments a..g, active-low
//   dp_n_o         decimal point, active-low
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned BLINK_HZ     = 2,
  parameter int unsigned N_DIGITS     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blink_mask_i,
  input  logic                  enable_i,
  output logic [N_DIGITS-1:0]   an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_n_o
);

  // SCAN_DIV must be >= 4 and BLANK_CYCLES < SCAN_DIV.
  localparam int unsigned SCAN_DIV  = CLK_FREQ_HZ / REFRESH_HZ;
  localparam int unsigned BLINK_DIV = CLK_FREQ_HZ / (2 * BLINK_HZ);
  localparam int unsigned ScanW     = $clog2(SCAN_DIV);
  localparam int unsigned BlinkW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned IdxW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [ScanW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]       digit_idx_q, digit_idx_d;
  logic [IdxW-1:0]       slot_idx_q, slot_idx_d;
  logic [BlinkW-1:0]     blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [4*N_DIGITS-1:0] digits_snap_q, digits_snap_d;
  logic [N_DIGITS-1:0]   dp_snap_q, dp_snap_d;
  logic [N_DIGITS-1:0]   blink_snap_q, blink_snap_d;
  logic                  snap_valid_q, snap_valid_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;

  logic                  scan_tc;
  logic                  blink_tc;
  logic [3:0]            cur_code;
  seg_t                  cur_seg;
  logic                  cur_dp;
  logic                  cur_blink;
  logic                  cur_lz;

  // Counter / slot sequencing.
  always_comb begin
    scan_tc       = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
    blink_tc      = (blink_cnt_q == BlinkW'(BLINK_DIV - 1));

    scan_cnt_d    = scan_tc ? '0 : scan_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    slot_idx_d    = slot_idx_q;
    digits_snap_d = digits_snap_q;
    dp_snap_d     = dp_snap_q;
    blink_snap_d  = blink_snap_q;
    snap_valid_d  = snap_valid_q;

    if (scan_tc) begin
      // The slot that starts now shows the digit digit_idx pointed at; the
      // pointer then moves on for the following slot.
      slot_idx_d    = digit_idx_q;
      digit_idx_d   = (digit_idx_q == IdxW'(N_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
      digits_snap_d = digits_i;
      dp_snap_d     = dp_i;
      blink_snap_d  = blink_mask_i;
      snap_valid_d  = 1'b1;
    end

    blink_cnt_d   = blink_tc ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_tc ? ~blink_phase_q : blink_phase_q;
  end

  assign cur_code  = digits_snap_q[{slot_idx_q, 2'b00} +: 4];
  assign cur_dp    = dp_snap_q[slot_idx_q];
  assign cur_blink = blink_snap_q[slot_idx_q];

  bcd_to_seg u_bcd_to_seg (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_blank;
  logic                lz_run;

  // lz_run stays set while every digit from the top down to k is a bare zero.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      lz_run      = lz_run && (digits_snap_q[4*k +: 4] == 4'h0) && !dp_snap_q[k];
      lz_blank[k] = lz_run;
    end
  end

  assign cur_lz = lz_blank[slot_idx_q];
`else
  assign cur_lz = 1'b0;
`endif

  // Registered outputs, one cycle behind the counter state.
  always_comb begin
    an_d   = '1;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    // Nothing is shown until the first snapshot exists.
    if (snap_valid_q && (scan_cnt_q >= ScanW'(BLANK_CYCLES))) begin
      if (enable_i) begin
        an_d[slot_idx_q] = 1'b0;
      end
      if (!(cur_blink && !blink_phase_q) && !cur_lz) begin
        seg_d  = cur_seg;
        dp_n_d = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scan_cnt_q    <= '0;
      digit_idx_q   <= '0;
      slot_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      digits_snap_q <= '0;
      dp_snap_q     <= '0;
      blink_snap_q  <= '0;
      snap_valid_q  <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_BLANK;
      dp_n_q        <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_idx_q   <= digit_idx_d;
      slot_idx_q    <= slot_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digits_snap_q <= digits_snap_d;
      dp_snap_q     <= dp_snap_d;
      blink_snap_q  <= blink_snap_d;
      snap_valid_q  <= snap_valid_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
    end
  end

  assign an_o   = an_q;
  assign seg_o  = seg_q;
  assign dp_n_o = dp_n_q;

endmodule
